// File: rtl/gpu_fill_rect_if.sv
// Bus bundle for gpu_fill_rect: corner/start request inputs and pixel stream outputs.
// abort_i is present only when GPU_FILL_RECT_ABORT_EN is defined.
interface gpu_fill_rect_if #(
   parameter int unsigned WIDTH_BITS  = 10,
   parameter int unsigned HEIGHT_BITS = 9
);
   logic [WIDTH_BITS-1:0]  x1_i;
   logic [HEIGHT_BITS-1:0] y1_i;
   logic [WIDTH_BITS-1:0]  x2_i;
   logic [HEIGHT_BITS-1:0] y2_i;
   logic                   start_i;
   logic [WIDTH_BITS-1:0]  x_o;
   logic [HEIGHT_BITS-1:0] y_o;
   logic                   done_o;
   logic                   busy_o;
`ifdef GPU_FILL_RECT_ABORT_EN
   logic                   abort_i;

   modport master (
      output x1_i, y1_i, x2_i, y2_i, start_i, abort_i,
      input  x_o, y_o, done_o, busy_o
   );
   modport slave (
      input  x1_i, y1_i, x2_i, y2_i, start_i, abort_i,
      output x_o, y_o, done_o, busy_o
   );
`else
   modport master (
      output x1_i, y1_i, x2_i, y2_i, start_i,
      input  x_o, y_o, done_o, busy_o
   );
   modport slave (
      input  x1_i, y1_i, x2_i, y2_i, start_i,
      output x_o, y_o, done_o, busy_o
   );
`endif
endinterface

// File: rtl/gpu_fill_rect.sv
// Axis-aligned filled-rectangle rasterizer: emits one pixel coordinate per clock, row-major.
// Optional mid-fill abort input enabled by defining GPU_FILL_RECT_ABORT_EN.
module gpu_fill_rect #(
   parameter int unsigned WIDTH_BITS  = 10,
   parameter int unsigned HEIGHT_BITS = 9
) (
   input  logic           clk,
   input  logic           rst,
   gpu_fill_rect_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q, state_nxt;
   logic [WIDTH_BITS-1:0]  x_q, x_nxt;
   logic [HEIGHT_BITS-1:0] y_q, y_nxt;
   logic [WIDTH_BITS-1:0]  xmin_q, xmin_nxt, xmax_q, xmax_nxt;
   logic [HEIGHT_BITS-1:0] ymin_q, ymin_nxt, ymax_q, ymax_nxt;
   logic                   busy_q, busy_nxt;
   logic                   done_q, done_nxt;
   logic                   abort;

`ifdef GPU_FILL_RECT_ABORT_EN
   assign abort = bus.abort_i;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         xmin_q  <= xmin_nxt;
         xmax_q  <= xmax_nxt;
         ymin_q  <= ymin_nxt;
         ymax_q  <= ymax_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      x_nxt     = x_q;
      y_nxt     = y_q;
      xmin_nxt  = xmin_q;
      xmax_nxt  = xmax_q;
      ymin_nxt  = ymin_q;
      ymax_nxt  = ymax_q;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               xmin_nxt  = (bus.x1_i < bus.x2_i) ? bus.x1_i : bus.x2_i;
               xmax_nxt  = (bus.x1_i < bus.x2_i) ? bus.x2_i : bus.x1_i;
               ymin_nxt  = (bus.y1_i < bus.y2_i) ? bus.y1_i : bus.y2_i;
               ymax_nxt  = (bus.y1_i < bus.y2_i) ? bus.y2_i : bus.y1_i;
               x_nxt     = xmin_nxt;
               y_nxt     = ymin_nxt;
               busy_nxt  = 1'b1;
               state_nxt = FILL;
            end
         end
         FILL: begin
            // Compare against latched bounds before incrementing so xmax/ymax at full scale never wrap.
            if (abort) begin
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (x_q < xmax_q) begin
               x_nxt    = x_q + WIDTH_BITS'(1);
               busy_nxt = 1'b1;
            end else if (y_q < ymax_q) begin
               x_nxt    = xmin_q;
               y_nxt    = y_q + HEIGHT_BITS'(1);
               busy_nxt = 1'b1;
            end else begin
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.x_o    = x_q;
   assign bus.y_o    = y_q;
   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;

endmodule

// File: tb/tb_gpu_fill_rect.sv
// Self-checking bench for gpu_fill_rect: randomized rectangles against a nested-loop pixel model.
// Abort scenario is compiled in when GPU_FILL_RECT_ABORT_EN is defined.
module tb_gpu_fill_rect;
   localparam int unsigned WB = 10;
   localparam int unsigned HB = 9;

   logic tb_clk = 1'b0;
   logic rst    = 1'b0;
   always #5 tb_clk = ~tb_clk;

   gpu_fill_rect_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus ();

   gpu_fill_rect #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
      .clk (tb_clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int exp_x[$], exp_y[$];
   int got_x[$], got_y[$];
   int overlap, timed_out, done_at_end, end_x, end_y, done_next, busy_next;

   // Reference: every inclusive coordinate of the normalised rectangle, row-major.
   function automatic void build_expected(input int ax, input int ay, input int bx, input int by);
      int x0, x1, y0, y1;
      x0 = (ax < bx) ? ax : bx;  x1 = (ax < bx) ? bx : ax;
      y0 = (ay < by) ? ay : by;  y1 = (ay < by) ? by : ay;
      exp_x.delete(); exp_y.delete();
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
         end
   endfunction

   // Issues one fill and records the busy pixel stream plus the cycles just after it.
   task automatic capture(input int ax, input int ay, input int bx, input int by,
                          input bit keep_start, input bit scramble);
      int cyc;
      got_x.delete(); got_y.delete();
      overlap = 0; timed_out = 0; cyc = 0;
      @(negedge tb_clk);
      bus.x1_i = WB'(ax); bus.y1_i = HB'(ay);
      bus.x2_i = WB'(bx); bus.y2_i = HB'(by);
      bus.start_i = 1'b1;
      @(negedge tb_clk);
      if (!keep_start) bus.start_i = 1'b0;
      while (bus.busy_o === 1'b1) begin
         if (cyc >= 4096) begin
            timed_out = 1;
            break;
         end
         got_x.push_back(int'(bus.x_o));
         got_y.push_back(int'(bus.y_o));
         if (bus.done_o !== 1'b0) overlap++;
         if (scramble) begin
            bus.x1_i = WB'($urandom); bus.y1_i = HB'($urandom);
            bus.x2_i = WB'($urandom); bus.y2_i = HB'($urandom);
         end
         @(negedge tb_clk);
         cyc++;
      end
      done_at_end = int'(bus.done_o);
      end_x = int'(bus.x_o);
      end_y = int'(bus.y_o);
      @(negedge tb_clk);
      done_next = int'(bus.done_o);
      busy_next = int'(bus.busy_o);
   endtask

   task automatic test_reset;
      bus.x1_i = '0; bus.y1_i = '0; bus.x2_i = '0; bus.y2_i = '0;
      bus.start_i = 1'b0;
`ifdef GPU_FILL_RECT_ABORT_EN
      bus.abort_i = 1'b0;
`endif
      #1 rst = 1'b1;
      #2;
      n_checks++;
      if (bus.x_o !== '0 || bus.y_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got x=%0d y=%0d busy=%b done=%b, want 0 0 0 0",
                  bus.x_o, bus.y_o, bus.busy_o, bus.done_o);
      end
      repeat (3) @(negedge tb_clk);
      rst = 1'b0;
      repeat (2) @(negedge tb_clk);
      n_checks++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.busy_o, bus.done_o);
      end
   endtask

   task automatic test_basic;
      build_expected(0, 0, 5, 6);
      capture(0, 0, 5, 6, 1'b1, 1'b0);
      n_checks++;
      if (timed_out != 0 || got_x.size() != 42) begin
         n_fail++;
         $display("FAIL basic_count: got %0d busy cycles (timeout=%0d), want 42", got_x.size(), timed_out);
      end
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
         n_checks++;
         if (got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i]) begin
            n_fail++;
            $display("FAIL basic_pixel[%0d]: got (%0d,%0d), want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
         end
      end
      n_checks++;
      if (overlap != 0 || done_at_end != 1 || end_x != 5 || end_y != 6 || done_next != 0) begin
         n_fail++;
         $display("FAIL basic_done: got overlap=%0d done=%0d at (%0d,%0d) next_done=%0d, want 0 1 (5,6) 0",
                  overlap, done_at_end, end_x, end_y, done_next);
      end
      // start still held: one IDLE cycle, then a fresh fill from (0,0)
      n_checks++;
      if (busy_next != 0) begin
         n_fail++;
         $display("FAIL basic_idle_gap: got busy=%0d, want 0", busy_next);
      end
      @(negedge tb_clk);
      n_checks++;
      if (bus.busy_o !== 1'b1 || bus.x_o !== WB'(0) || bus.y_o !== HB'(0)) begin
         n_fail++;
         $display("FAIL basic_retrigger: got busy=%b (%0d,%0d), want 1 (0,0)", bus.busy_o, bus.x_o, bus.y_o);
      end
      bus.start_i = 1'b0;
      repeat (60) @(negedge tb_clk);
   endtask

   task automatic test_swapped;
      build_expected(0, 0, 5, 6);
      capture(5, 6, 0, 0, 1'b0, 1'b0);
      n_checks++;
      if (timed_out != 0 || got_x.size() != exp_x.size()) begin
         n_fail++;
         $display("FAIL swapped_count: got %0d, want %0d", got_x.size(), exp_x.size());
      end
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
         n_checks++;
         if (got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i]) begin
            n_fail++;
            $display("FAIL swapped_pixel[%0d]: got (%0d,%0d), want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
         end
      end
      n_checks++;
      if (done_at_end != 1 || done_next != 0 || overlap != 0) begin
         n_fail++;
         $display("FAIL swapped_done: got done=%0d next=%0d overlap=%0d, want 1 0 0", done_at_end, done_next, overlap);
      end
   endtask

   task automatic test_single;
      capture(3, 3, 3, 3, 1'b0, 1'b0);
      n_checks++;
      if (got_x.size() != 1 || got_x[0] != 3 || got_y[0] != 3) begin
         n_fail++;
         $display("FAIL single_pixel: got %0d busy cycles first=(%0d,%0d), want 1 at (3,3)",
                  got_x.size(), (got_x.size() > 0) ? got_x[0] : -1, (got_y.size() > 0) ? got_y[0] : -1);
      end
      n_checks++;
      if (done_at_end != 1 || done_next != 0 || busy_next != 0) begin
         n_fail++;
         $display("FAIL single_done: got done=%0d next_done=%0d next_busy=%0d, want 1 0 0", done_at_end, done_next, busy_next);
      end
      n_checks++;
      if (bus.x_o !== WB'(3) || bus.y_o !== HB'(3)) begin
         n_fail++;
         $display("FAIL single_hold: got (%0d,%0d) in IDLE, want (3,3)", bus.x_o, bus.y_o);
      end
   endtask

   task automatic test_max_extent;
      int zeros;
      build_expected(1020, 510, 1023, 511);
      capture(1023, 511, 1020, 510, 1'b0, 1'b0);
      zeros = 0;
      foreach (got_x[i]) if (got_x[i] == 0) zeros++;
      n_checks++;
      if (got_x.size() != 8 || zeros != 0) begin
         n_fail++;
         $display("FAIL max_count: got %0d pixels with %0d at x=0, want 8 and 0", got_x.size(), zeros);
      end
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
         n_checks++;
         if (got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i]) begin
            n_fail++;
            $display("FAIL max_pixel[%0d]: got (%0d,%0d), want (%0d,%0d)", i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
         end
      end
      n_checks++;
      if (done_at_end != 1 || end_x != 1023 || end_y != 511) begin
         n_fail++;
         $display("FAIL max_done: got done=%0d at (%0d,%0d), want 1 at (1023,511)", done_at_end, end_x, end_y);
      end
   endtask

   task automatic test_random;
      int ax, ay, bx, by;
      for (int t = 0; t < 10; t++) begin
         ax = $urandom_range(0, 1023); ay = $urandom_range(0, 511);
         bx = ax + $urandom_range(0, 7) * (($urandom_range(0, 1) == 1) ? 1 : -1);
         by = ay + $urandom_range(0, 7) * (($urandom_range(0, 1) == 1) ? 1 : -1);
         if (bx < 0) bx = 0;
         if (bx > 1023) bx = 1023;
         if (by < 0) by = 0;
         if (by > 511) by = 511;
         build_expected(ax, ay, bx, by);
         // corners are scrambled during the fill; latched bounds must be unaffected
         capture(ax, ay, bx, by, 1'b0, 1'b1);
         n_checks++;
         if (timed_out != 0 || got_x.size() != exp_x.size() || overlap != 0 || done_at_end != 1 || done_next != 0) begin
            n_fail++;
            $display("FAIL rand%0d_shape: got n=%0d overlap=%0d done=%0d next=%0d, want n=%0d 0 1 0",
                     t, got_x.size(), overlap, done_at_end, done_next, exp_x.size());
         end
         for (int i = 0; i < got_x.size() && i < exp_x.size(); i++) begin
            n_checks++;
            if (got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i]) begin
               n_fail++;
               $display("FAIL rand%0d_pixel[%0d]: got (%0d,%0d), want (%0d,%0d)", t, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset;
      int cyc, stray;
      @(negedge tb_clk);
      bus.x1_i = WB'(2); bus.y1_i = HB'(2); bus.x2_i = WB'(4); bus.y2_i = HB'(4);
      bus.start_i = 1'b1;
      @(negedge tb_clk);
      bus.start_i = 1'b0;
      cyc = 0;
      while (!(bus.busy_o === 1'b1 && bus.x_o === WB'(3) && bus.y_o === HB'(3)) && cyc < 50) begin
         @(negedge tb_clk);
         cyc++;
      end
      n_checks++;
      if (cyc != 4) begin
         n_fail++;
         $display("FAIL arst_reach: got (3,3) after %0d cycles, want 4", cyc);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.x_o !== '0 || bus.y_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_immediate: got x=%0d y=%0d busy=%b done=%b, want 0 0 0 0",
                  bus.x_o, bus.y_o, bus.busy_o, bus.done_o);
      end
      @(negedge tb_clk);
      rst = 1'b0;
      stray = 0;
      repeat (12) begin
         @(negedge tb_clk);
         if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.x_o !== '0) stray++;
      end
      n_checks++;
      if (stray != 0) begin
         n_fail++;
         $display("FAIL arst_no_resume: got %0d active cycles after reset, want 0", stray);
      end
   endtask

`ifdef GPU_FILL_RECT_ABORT_EN
   task automatic test_abort;
      int cyc;
      @(negedge tb_clk);
      bus.x1_i = WB'(0); bus.y1_i = HB'(0); bus.x2_i = WB'(9); bus.y2_i = HB'(9);
      bus.start_i = 1'b1;
      @(negedge tb_clk);
      bus.start_i = 1'b0;
      cyc = 0;
      while (!(bus.busy_o === 1'b1 && bus.x_o === WB'(4) && bus.y_o === HB'(1)) && cyc < 200) begin
         @(negedge tb_clk);
         cyc++;
      end
      n_checks++;
      if (cyc != 14) begin
         n_fail++;
         $display("FAIL abort_reach: got (4,1) after %0d cycles, want 14", cyc);
      end
      bus.abort_i = 1'b1;
      @(negedge tb_clk);
      bus.abort_i = 1'b0;
      n_checks++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b1 || bus.x_o !== WB'(4) || bus.y_o !== HB'(1)) begin
         n_fail++;
         $display("FAIL abort_done: got busy=%b done=%b (%0d,%0d), want 0 1 (4,1)", bus.busy_o, bus.done_o, bus.x_o, bus.y_o);
      end
      @(negedge tb_clk);
      n_checks++;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.x_o !== WB'(4) || bus.y_o !== HB'(1)) begin
         n_fail++;
         $display("FAIL abort_after: got busy=%b done=%b (%0d,%0d), want 0 0 (4,1)", bus.busy_o, bus.done_o, bus.x_o, bus.y_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_swapped();
      test_single();
      test_max_extent();
      test_random();
      test_async_reset();
`ifdef GPU_FILL_RECT_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gpu_fill_rect.md
Name: gpu_fill_rect

Overview:
- Rasterizer for axis-aligned filled rectangles in the GPU pipeline.
- On a start request it latches two corner coordinates and emits every pixel coordinate inside the rectangle, one per clock, in row-major order.
- Its outputs feed the downstream pixel-write/framebuffer stage, which consumes (x_o, y_o) on every cycle where busy_o is high.

Parameters:
- WIDTH_BITS, 10, bit width of x coordinates (screen width up to 1024).
- HEIGHT_BITS, 9, bit width of y coordinates (screen height up to 512).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- x1_i  in  WIDTH_BITS  corner A x.
- y1_i  in  HEIGHT_BITS  corner A y.
- x2_i  in  WIDTH_BITS  corner B x.
- y2_i  in  HEIGHT_BITS  corner B y.
- start_i  in  1  fill request, level-sampled in IDLE.
- x_o  out  WIDTH_BITS  current pixel x.
- y_o  out  HEIGHT_BITS  current pixel y.
- done_o  out  1  one-cycle pulse after the last pixel.
- busy_o  out  1  high while (x_o, y_o) is a valid pixel.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst). All outputs are registered.
- Reset values: state IDLE, x_o=0, y_o=0, busy_o=0, done_o=0, and all internal bound registers 0.
- Assertion of rst at any time, including mid-fill, forces the reset values immediately. No partial fill resumes after reset.
- States: IDLE, FILL, DONE.
- IDLE, start_i sampled high at edge k:
  - Latch xmin=min(x1_i,x2_i), xmax=max(x1_i,x2_i), ymin=min(y1_i,y2_i), ymax=max(y1_i,y2_i).
  - Go to FILL.
  - After edge k: x_o=xmin, y_o=ymin, busy_o=1.
- IDLE with start_i low: hold outputs, busy_o=0, done_o=0.
- FILL, each edge:
  - If x_o<xmax: x_o increments.
  - Else if y_o<ymax: x_o becomes xmin and y_o increments.
  - Else (pixel (xmax,ymax) was just emitted): go to DONE, busy_o=0, done_o=1, and x_o/y_o hold at (xmax,ymax).
- DONE: one cycle only, then IDLE with done_o=0.
  - If start_i is still high in the following IDLE cycle, a new fill starts; a continuously held start re-triggers.
  - IDLE therefore lasts at least 1 cycle between fills.
- Bounds are inclusive. busy_o is high for exactly (xmax-xmin+1)*(ymax-ymin+1) consecutive cycles.
- Each coordinate appears exactly once, and no out-of-range coordinate is ever presented while busy_o=1.
- Inputs x1_i..y2_i and start_i are ignored outside IDLE. Corner changes during FILL have no effect.
- Degenerate rectangles:
  - Single pixel gives 1 busy cycle.
  - Single row (ymin=ymax) and single column (xmin=xmax) are handled without special cases.
- Comparisons use the latched bounds, so no counter wrap occurs even at xmax=2^WIDTH_BITS-1 or ymax=2^HEIGHT_BITS-1. Comparison precedes increment.
- done_o and busy_o are never high in the same cycle.

Optional Feature:
- Macro: GPU_FILL_RECT_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i high at an edge while in FILL: go to DONE on that edge (busy_o=0, done_o=1 next cycle), and x_o/y_o hold their last values.
  - abort_i is ignored in IDLE and DONE.
  - abort_i has priority over the normal FILL advance.
- Not defined: no abort_i port exists, and every fill runs to completion.

Test Plan:
- Reset then corners (0,0),(5,6), start held high for 50 cycles -> 42 busy cycles in order (0,0),(1,0)..(5,0),(0,1)..(5,6); done_o pulses once on the next cycle; a new fill restarts at (0,0) after one IDLE cycle.
- Swapped corners (5,6),(0,0) -> output sequence and count identical to the previous scenario.
- Single pixel (3,3),(3,3) -> exactly 1 busy cycle at (3,3), then done_o for 1 cycle.
- Maximum extent: x (1020,1023), y (510,511) -> 8 pixels; x_o never wraps to 0 while busy_o=1; done_o asserted after (1023,511).
- Corners (2,2),(4,4); rst asserted asynchronously at pixel (3,3) -> outputs zero immediately, busy_o=0, state IDLE; with start low no further pixels are emitted.
- With GPU_FILL_RECT_ABORT_EN, corners (0,0),(9,9), abort_i pulsed at pixel (4,1) -> busy_o low next cycle, done_o one pulse, x_o/y_o hold (4,1).
